// File: rtl/uart_byte_to_bcd.sv
// Byte-to-BCD converter: accepts one byte via valid/ready and produces three decimal digits
// after eight shift-add-3 iterations, with optional leading-zero blanking (code 4'hF).
module uart_byte_to_bcd #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] digit_hundreds,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_ones
);

    localparam logic [3:0] BlankCode = 4'hF;
    // Reset display is "  0" with blanking, "000" without.
    localparam logic [3:0] RstUpper  = BLANK_LEADING ? BlankCode : 4'h0;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [19:0] work_q, work_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;

    logic [11:0] bcd_corr;
    logic [19:0] work_shifted;
    logic [3:0]  new_hund;
    logic [3:0]  new_tens;
    logic [3:0]  new_ones;

    // Add-3 correction on every nibble >= 5, then shift the whole register left.
    always_comb begin
        bcd_corr = work_q[19:8];
        for (int i = 0; i < 3; i++) begin
            if (work_q[8+4*i +: 4] >= 4'd5) begin
                bcd_corr[4*i +: 4] = work_q[8+4*i +: 4] + 4'd3;
            end
        end
        work_shifted = {bcd_corr[10:0], work_q[7:0], 1'b0};
    end

    always_comb begin
        new_hund = work_shifted[19:16];
        new_tens = work_shifted[15:12];
        new_ones = work_shifted[11:8];
        if (BLANK_LEADING && (work_shifted[19:16] == 4'd0)) begin
            new_hund = BlankCode;
            if (work_shifted[15:12] == 4'd0) begin
                new_tens = BlankCode;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_valid_d = 1'b0;
        hund_d      = hund_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d  = {12'h000, in_data};
                    cnt_d   = 3'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                work_d = work_shifted;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    hund_d      = new_hund;
                    tens_d      = new_tens;
                    ones_d      = new_ones;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            work_q      <= 20'h00000;
            out_valid_q <= 1'b0;
            hund_q      <= RstUpper;
            tens_q      <= RstUpper;
            ones_q      <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_valid_q <= out_valid_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
        end
    end

    assign in_ready       = (state_q == StIdle);
    assign out_valid      = out_valid_q;
    assign digit_hundreds = hund_q;
    assign digit_tens     = tens_q;
    assign digit_ones     = ones_q;

endmodule

// File: tb/tb_uart_byte_to_bcd.sv
// Bench for uart_byte_to_bcd: a blanking and a raw instance share stimulus and are compared
// against decimal arithmetic on the accepted byte.
module tb_uart_byte_to_bcd;

    logic       clk;
    logic       rstn;
    logic       in_valid;
    logic [7:0] in_data;

    logic       rdy_b, ov_b, rdy_r, ov_r;
    logic [3:0] dh_b, dt_b, do_b, dh_r, dt_r, do_r;

    int checks = 0;
    int errors = 0;

    uart_byte_to_bcd #(.BLANK_LEADING(1'b1)) u_dut_blank (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (rdy_b),
        .out_valid      (ov_b),
        .digit_hundreds (dh_b),
        .digit_tens     (dt_b),
        .digit_ones     (do_b)
    );

    uart_byte_to_bcd #(.BLANK_LEADING(1'b0)) u_dut_raw (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (rdy_r),
        .out_valid      (ov_r),
        .digit_hundreds (dh_r),
        .digit_tens     (dt_r),
        .digit_ones     (do_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_digits(input int v, input bit blank);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        if (blank && h == 0) begin
            h = 15;
            if (t == 0) t = 15;
        end
        return {h[3:0], t[3:0], o[3:0]};
    endfunction

    task automatic check_digits(input string tag, input int v);
        check({tag, "_blank"}, {20'h0, dh_b, dt_b, do_b}, {20'h0, ref_digits(v, 1'b1)});
        check({tag, "_raw"}, {20'h0, dh_r, dt_r, do_r}, {20'h0, ref_digits(v, 1'b0)});
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!rdy_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_b) check("ready_timeout", {31'h0, rdy_b}, 32'd1);
    endtask

    // Present v for one cycle, then verify latency, busy window, single pulse and digits.
    task automatic send_and_check(input int v);
        int  n;
        bit  busy_ok;
        wait_ready();
        in_valid = 1'b1;
        in_data  = v[7:0];
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        busy_ok  = 1'b1;
        for (n = 1; n <= 20; n++) begin
            if (ov_b) break;
            if (rdy_b || rdy_r || ov_r) busy_ok = 1'b0;
            @(negedge clk);
            in_data = 8'($urandom);
        end
        check("latency", n - 1, 32'd8);
        check("busy_low", {31'h0, busy_ok}, 32'd1);
        check("pulse_raw", {31'h0, ov_r}, 32'd1);
        check("ready_back", {31'h0, rdy_b}, 32'd1);
        check_digits("digits", v);
        @(negedge clk);
        check("pulse_single", {31'h0, ov_b}, 32'd0);
        check_digits("hold", v);
    endtask

    initial begin
        int q[$];
        int last_acc, n_acc, v;
        bit ok;

        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, rdy_b}, 32'd1);
        check("rst_valid", {31'h0, ov_b}, 32'd0);
        check_digits("rst", 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rel_ready", {31'h0, rdy_b}, 32'd1);
        check("rel_valid", {31'h0, ov_r}, 32'd0);
        check_digits("rel", 0);

        send_and_check(255);
        send_and_check(9);
        send_and_check(100);
        send_and_check(0);

        for (int i = 0; i < 256; i++) begin
            send_and_check(i);
            check("hund_max", {31'h0, dh_r > 4'd2}, 32'd0);
        end

        repeat (30) send_and_check(int'($urandom_range(255, 0)));

        // Streaming: valid held high, data changes every cycle.
        last_acc = -1;
        n_acc    = 0;
        for (int cyc = 0; cyc < 240; cyc++) begin
            in_valid = (cyc < 200);
            in_data  = 8'($urandom);
            if (ov_b) begin
                if (q.size() == 0) check("stream_extra", {31'h0, ov_b}, 32'd0);
                else begin
                    v = q.pop_front();
                    check_digits("stream", v);
                end
            end
            if (in_valid && rdy_b) begin
                if (last_acc >= 0) check("stream_gap", cyc - last_acc, 32'd9);
                last_acc = cyc;
                n_acc++;
                q.push_back(int'(in_data));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_accepts", {31'h0, n_acc >= 20}, 32'd1);
        check("stream_drained", q.size(), 32'd0);

        // Reset at E4 of a conversion of 123, with in_valid asserted during reset.
        send_and_check(47);
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'd123;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn     = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(negedge clk);
        check("midrst_valid", {31'h0, ov_b}, 32'd0);
        check("midrst_ready", {31'h0, rdy_b}, 32'd1);
        check_digits("midrst", 0);
        @(negedge clk);
        rstn     = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("postrst_ready", {31'h0, rdy_b}, 32'd1);
        ok = 1'b1;
        repeat (14) begin
            if (ov_b || ov_r) ok = 1'b0;
            @(negedge clk);
        end
        check("postrst_no_pulse", {31'h0, ok}, 32'd1);
        check_digits("postrst", 0);

        // Hold: digits stay put with no traffic.
        send_and_check(7);
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (ov_b || ov_r || {dh_r, dt_r, do_r} != 12'h007) ok = 1'b0;
        end
        check("hold50", {31'h0, ok}, 32'd1);
        check_digits("hold50", 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
